// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - RV32I decode stage: register file, field/immediate/control decode, ID/EX register
// Optional feature macro: ILLEGAL_TRAP_EN (flags unrecognised opcodes and bad OP funct7)
module instr_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if_id,
  input  logic [31:0] PC_if_id,
  input  logic        branch_mem_if,
  input  logic        stall_id,
  input  logic        reg_write_wb_id,
  input  logic [4:0]  rd_wb_id,
  input  logic [31:0] rd_data_wb_id,
  output logic        valid_id_ex,
  output logic [31:0] PC_id_ex,
  output logic [31:0] rs1_data_id_ex,
  output logic [31:0] rs2_data_id_ex,
  output logic [31:0] imm_id_ex,
  output logic [4:0]  rs1_id_ex,
  output logic [4:0]  rs2_id_ex,
  output logic [4:0]  rd_id_ex,
  output logic [2:0]  funct3_id_ex,
  output logic [3:0]  alu_op_id_ex,
  output logic        alu_src_id_ex,
  output logic        mem_read_id_ex,
  output logic        mem_write_id_ex,
  output logic        reg_write_id_ex,
  output logic        branch_id_ex,
  output logic        jump_id_ex,
  output logic [1:0]  wb_sel_id_ex,
  output logic        illegal_id_ex
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [31:0] r_rf [0:31];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [3:0]  w_alu_f3;
  logic        w_op_f7_ok;

  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_branch;
  logic        w_jump;
  logic [1:0]  w_wb_sel;
  logic        w_load;
  logic        w_keep_ctrl;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [3:0]  r_alu_op;
  logic        r_alu_src;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_reg_write;
  logic        r_branch;
  logic        r_jump;
  logic [1:0]  r_wb_sel;

  assign w_opcode = instr_if_id[6:0];
  assign w_rd     = instr_if_id[11:7];
  assign w_funct3 = instr_if_id[14:12];
  assign w_rs1    = instr_if_id[19:15];
  assign w_rs2    = instr_if_id[24:20];
  assign w_alt    = instr_if_id[30];

  // Register file: x0 is never written; writes continue through stall and flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (reg_write_wb_id && (rd_wb_id != 5'd0)) begin
      r_rf[rd_wb_id] <= rd_data_wb_id;
    end
  end

  // Read ports with WB bypass so a same-cycle writeback is seen by this decode.
  always_comb begin
    w_rs1_data = r_rf[w_rs1];
    if (w_rs1 == 5'd0) begin
      w_rs1_data = '0;
    end else if (reg_write_wb_id && (rd_wb_id == w_rs1)) begin
      w_rs1_data = rd_data_wb_id;
    end
  end

  always_comb begin
    w_rs2_data = r_rf[w_rs2];
    if (w_rs2 == 5'd0) begin
      w_rs2_data = '0;
    end else if (reg_write_wb_id && (rd_wb_id == w_rs2)) begin
      w_rs2_data = rd_data_wb_id;
    end
  end

  assign w_imm_i = {{20{instr_if_id[31]}}, instr_if_id[31:20]};
  assign w_imm_s = {{20{instr_if_id[31]}}, instr_if_id[31:25], instr_if_id[11:7]};
  assign w_imm_b = {{19{instr_if_id[31]}}, instr_if_id[31], instr_if_id[7],
                    instr_if_id[30:25], instr_if_id[11:8], 1'b0};
  assign w_imm_u = {instr_if_id[31:12], 12'h000};
  assign w_imm_j = {{11{instr_if_id[31]}}, instr_if_id[31], instr_if_id[19:12],
                    instr_if_id[20], instr_if_id[30:21], 1'b0};

  // SUB only exists for register-register ops; SRA/SRAI share the instr[30] select.
  always_comb begin
    case (w_funct3)
      3'b000:  w_alu_f3 = ((w_opcode == OPC_OP) && w_alt) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = w_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic w_illegal;
  logic r_illegal;

  assign w_op_f7_ok = (instr_if_id[31:25] == 7'h00) ||
                      ((instr_if_id[31:25] == 7'h20) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

  always_comb begin
    case (w_opcode)
      OPC_OP:                                  w_illegal = !w_op_f7_ok;
      OPC_OP_IMM, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_LUI, OPC_AUIPC:                      w_illegal = 1'b0;
      default:                                 w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal <= 1'b0;
    end else if (!stall_id || branch_mem_if) begin
      r_illegal <= w_illegal && !branch_mem_if;
    end
  end

  assign illegal_id_ex = r_illegal;
`else
  assign w_op_f7_ok    = 1'b1;
  assign illegal_id_ex = 1'b0;
`endif

  always_comb begin
    w_imm       = '0;
    w_alu_op    = ALU_ADD;
    w_alu_src   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_wb_sel    = WB_ALU;
    case (w_opcode)
      OPC_OP: begin
        if (w_op_f7_ok) begin
          w_alu_op    = w_alu_f3;
          w_reg_write = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_imm       = w_imm_i;
        w_alu_op    = w_alu_f3;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_LOAD: begin
        w_imm       = w_imm_i;
        w_alu_src   = 1'b1;
        w_mem_read  = 1'b1;
        w_reg_write = 1'b1;
        w_wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        w_imm       = w_imm_s;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm       = w_imm_b;
        w_alu_op    = ALU_SUB;
        w_branch    = 1'b1;
      end
      OPC_JAL: begin
        w_imm       = w_imm_j;
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
        w_wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        w_imm       = w_imm_i;
        w_alu_src   = 1'b1;
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
        w_wb_sel    = WB_PC4;
      end
      OPC_LUI: begin
        w_imm       = w_imm_u;
        w_alu_op    = ALU_PASS_B;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm       = w_imm_u;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      default: begin
        w_imm = '0;
      end
    endcase
  end

  assign w_load      = !stall_id || branch_mem_if;
  assign w_keep_ctrl = !branch_mem_if;

  // Flush beats stall: a squashed slot still loads, only with its side-effecting controls cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_pc        <= RESET_PC;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_alu_op    <= '0;
      r_alu_src   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_wb_sel    <= '0;
    end else if (w_load) begin
      r_valid     <= w_keep_ctrl;
      r_pc        <= PC_if_id;
      r_rs1_data  <= w_rs1_data;
      r_rs2_data  <= w_rs2_data;
      r_imm       <= w_imm;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= (w_reg_write && w_keep_ctrl) ? w_rd : 5'd0;
      r_funct3    <= w_funct3;
      r_alu_op    <= w_alu_op;
      r_alu_src   <= w_alu_src;
      r_mem_read  <= w_mem_read && w_keep_ctrl;
      r_mem_write <= w_mem_write && w_keep_ctrl;
      r_reg_write <= w_reg_write && w_keep_ctrl;
      r_branch    <= w_branch && w_keep_ctrl;
      r_jump      <= w_jump && w_keep_ctrl;
      r_wb_sel    <= w_wb_sel;
    end
  end

  assign valid_id_ex     = r_valid;
  assign PC_id_ex        = r_pc;
  assign rs1_data_id_ex  = r_rs1_data;
  assign rs2_data_id_ex  = r_rs2_data;
  assign imm_id_ex       = r_imm;
  assign rs1_id_ex       = r_rs1;
  assign rs2_id_ex       = r_rs2;
  assign rd_id_ex        = r_rd;
  assign funct3_id_ex    = r_funct3;
  assign alu_op_id_ex    = r_alu_op;
  assign alu_src_id_ex   = r_alu_src;
  assign mem_read_id_ex  = r_mem_read;
  assign mem_write_id_ex = r_mem_write;
  assign reg_write_id_ex = r_reg_write;
  assign branch_id_ex    = r_branch;
  assign jump_id_ex      = r_jump;
  assign wb_sel_id_ex    = r_wb_sel;

endmodule
